player_motion_engine: RTL and testbench

PLAYER_MOTION_ENGINE -- requirements
Module: player_motion_engine

---
 rtl/player_motion_engine.sv | 148 ++++++++++++++
 tb/tb_player_motion_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_engine.sv
// Player x motion and single-bullet flight, advanced once per frameTick; all outputs registered (one cycle after the sampling edge), no backpressure.
// Define SHOT_COOLDOWN_EN to add a fire lockout of COOLDOWN_FRAMES ticks after each bullet retires.
module player_motion_engine #(
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int PLAYER_Y        = 440,
    parameter int STEP            = 4,
    parameter int BULLET_STEP     = 8,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frameTick,
    input  logic [31:0] speedData,
    input  logic        shootData,
    input  logic        hit,
    output logic [9:0]  playerX,
    output logic        bulletActive,
    output logic [9:0]  bulletX,
    output logic [8:0]  bulletY,
    output logic        fireAck,
    output logic [7:0]  shotCount
);

    localparam int RESET_X = (X_MIN + X_MAX) / 2;
    localparam int CD_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FLY  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_player_x;
    logic [9:0]  r_bullet_x;
    logic [8:0]  r_bullet_y;
    logic        r_fire_ack;
    logic [7:0]  r_shots;

    logic [9:0]  w_next_x;
    logic [9:0]  w_bx_nxt;
    logic [8:0]  w_by_nxt;
    logic        w_fire_nxt;
    logic [7:0]  w_shots_nxt;
    logic        w_retire;
    logic        w_fire_ok;
    int          w_px;

    assign w_px = int'(r_player_x);

    // Clamp before stepping so the position never wraps through zero or past X_MAX.
    always_comb begin
        w_next_x = r_player_x;
        if (speedData == 32'h0000_0001) begin
            if (w_px > X_MAX - STEP) w_next_x = 10'(X_MAX);
            else                     w_next_x = r_player_x + 10'(STEP);
        end else if (speedData == 32'hFFFF_FFFF) begin
            if (w_px < X_MIN + STEP) w_next_x = 10'(X_MIN);
            else                     w_next_x = r_player_x - 10'(STEP);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bx_nxt    = r_bullet_x;
        w_by_nxt    = r_bullet_y;
        w_fire_nxt  = 1'b0;
        w_shots_nxt = r_shots;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frameTick && shootData && w_fire_ok) begin
                    w_state_nxt = S_FLY;
                    w_bx_nxt    = r_player_x;
                    w_by_nxt    = 9'(PLAYER_Y - 1);
                    w_fire_nxt  = 1'b1;
                    w_shots_nxt = r_shots + 8'd1;
                end
            end
            S_FLY: begin
                // A collision wins over the frame move, even on a tick edge.
                if (hit) begin
                    w_state_nxt = S_IDLE;
                    w_retire    = 1'b1;
                end else if (frameTick) begin
                    if (r_bullet_y >= 9'(BULLET_STEP)) begin
                        w_by_nxt = r_bullet_y - 9'(BULLET_STEP);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_retire    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef SHOT_COOLDOWN_EN
    logic [CD_W-1:0] r_cooldown;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cooldown <= '0;
        end else if (w_retire) begin
            r_cooldown <= CD_W'(COOLDOWN_FRAMES);
        end else if (frameTick && (r_cooldown != '0)) begin
            r_cooldown <= r_cooldown - 1'b1;
        end
    end

    assign w_fire_ok = (r_cooldown == '0);
`else
    logic [CD_W-1:0] w_cooldown;

    assign w_cooldown = '0;
    assign w_fire_ok  = (w_cooldown == '0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_player_x <= 10'(RESET_X);
            r_bullet_x <= '0;
            r_bullet_y <= '0;
            r_fire_ack <= 1'b0;
            r_shots    <= '0;
        end else begin
            if (frameTick) r_player_x <= w_next_x;
            r_bullet_x <= w_bx_nxt;
            r_bullet_y <= w_by_nxt;
            r_fire_ack <= w_fire_nxt;
            r_shots    <= w_shots_nxt;
        end
    end

    assign playerX      = r_player_x;
    assign bulletActive = (r_state == S_FLY);
    assign bulletX      = r_bullet_x;
    assign bulletY      = r_bullet_y;
    assign fireAck      = r_fire_ack;
    assign shotCount    = r_shots;

endmodule

// File: tb/tb_player_motion_engine.sv
// Directed bench for player_motion_engine; a second instance with shifted geometry reaches positions the default grid cannot.
module tb_player_motion_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frameTick = 1'b0;
    logic [31:0] speedData = 32'h0;
    logic        shootData = 1'b0;
    logic        hit = 1'b0;

    logic [9:0]  playerX, bulletX, p2_x, p2_bx;
    logic [8:0]  bulletY, p2_by;
    logic        bulletActive, fireAck, p2_active, p2_ack;
    logic [7:0]  shotCount, p2_shots;

    int n_cmp = 0;
    int n_err = 0;
    int first_launch;
    int launch_ok;

    always #5 clock = ~clock;

    player_motion_engine dut (
        .clock(clock), .reset(reset), .frameTick(frameTick), .speedData(speedData),
        .shootData(shootData), .hit(hit), .playerX(playerX), .bulletActive(bulletActive),
        .bulletX(bulletX), .bulletY(bulletY), .fireAck(fireAck), .shotCount(shotCount)
    );

    // Reset x = 322 (2 mod 4) and bullet start 440 (0 mod 8).
    player_motion_engine #(.X_MAX(645), .PLAYER_Y(441)) dut2 (
        .clock(clock), .reset(reset), .frameTick(frameTick), .speedData(speedData),
        .shootData(shootData), .hit(hit), .playerX(p2_x), .bulletActive(p2_active),
        .bulletX(p2_bx), .bulletY(p2_by), .fireAck(p2_ack), .shotCount(p2_shots)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        frameTick = 1'b1;
        @(negedge clock);
        frameTick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hit_pulse(input logic with_tick);
        @(negedge clock);
        hit = 1'b1;
        frameTick = with_tick;
        @(negedge clock);
        hit = 1'b0;
        frameTick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Tick with shootData held until the bullet launches; launch_ok=0 if the bound expires.
    task automatic wait_launch(output int ok);
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            tick();
            if (bulletActive) ok = 1;
        end
    endtask

    initial begin
        #12;
        check("rst_playerX", playerX, 319);
        check("rst_active", bulletActive, 0);
        check("rst_bulletX", bulletX, 0);
        check("rst_bulletY", bulletY, 0);
        check("rst_fireAck", fireAck, 0);
        check("rst_shotCount", shotCount, 0);
        check("rst_p2_x", p2_x, 322);
        @(negedge clock);
        reset = 1'b1;

        // Right-move clamp
        speedData = 32'h0000_0001;
        ticks(79);
        check("right_79", playerX, 635);
        tick();
        check("right_80_clamp", playerX, 639);
        ticks(20);
        check("right_100_hold", playerX, 639);
        speedData = 32'h0000_0002;
        tick();
        check("speed_other_hold", playerX, 639);

        // Left-move clamp from x=2
        do_reset();
        speedData = 32'hFFFF_FFFF;
        ticks(80);
        check("left_p2_at2", p2_x, 2);
        check("left_dut_clamp0", playerX, 0);
        tick();
        check("left_p2_to0", p2_x, 0);
        tick();
        check("left_p2_stays0", p2_x, 0);

        // Launch from x=100 while moving right; bulletX takes pre-move x
        speedData = 32'h0000_0001;
        ticks(25);
        check("pos_100", playerX, 100);
        shootData = 1'b1;
        tick();
        shootData = 1'b0;
        speedData = 32'h0;
        check("launch_fireAck", fireAck, 1);
        check("launch_bulletX", bulletX, 100);
        check("launch_bulletY", bulletY, 439);
        check("launch_shots", shotCount, 1);
        check("launch_active", bulletActive, 1);
        check("launch_playerX", playerX, 104);
        @(negedge clock);
        check("fireAck_one_cycle", fireAck, 0);
        ticks(54);
        check("fly_54_bulletY", bulletY, 7);
        check("fly_54_active", bulletActive, 1);
        tick();
        check("offscreen_retire", bulletActive, 0);
        check("idle_hold_bulletY", bulletY, 7);
        check("idle_hold_bulletX", bulletX, 100);

        // Hit coincident with tick at bulletY=200 (dut2) / 199 (dut)
        do_reset();
        shootData = 1'b1;
        tick();
        shootData = 1'b0;
        ticks(30);
        check("p2_at_200", p2_by, 200);
        check("dut_at_199", bulletY, 199);
        hit_pulse(1'b1);
        check("hit_tick_idle", bulletActive, 0);
        check("hit_tick_p2_y", p2_by, 200);
        check("hit_tick_dut_y", bulletY, 199);
        hit_pulse(1'b0);
        check("hit_idle_ignored", bulletActive, 0);
        check("hit_idle_shots", shotCount, 1);

        // Auto-fire relaunch delay after retirement
        shootData = 1'b1;
        first_launch = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bulletActive && first_launch == 0) first_launch = i;
        end
`ifdef SHOT_COOLDOWN_EN
        check("relaunch_tick", first_launch, 16);
`else
        check("relaunch_tick", first_launch, 1);
`endif
        check("relaunch_shots", shotCount, 2);

        // shotCount wrap via 256 launch/hit cycles
        do_reset();
        shootData = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            wait_launch(launch_ok);
            if (n == 255) check("shots_255", shotCount, 255);
            hit_pulse(1'b0);
        end
        check("shots_wrap0", shotCount, 0);

        // Reset asserted mid-flight
        speedData = 32'h0000_0001;
        wait_launch(launch_ok);
        check("midflight_launched", launch_ok, 1);
        shootData = 1'b0;
        ticks(5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_active", bulletActive, 0);
        check("midrst_playerX", playerX, 319);
        check("midrst_bulletY", bulletY, 0);
        check("midrst_shots", shotCount, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        speedData = 32'h0;
        tick();
        check("post_rst_active", bulletActive, 0);
        check("post_rst_playerX", playerX, 319);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
